// File: rtl/fir_pkg.sv
// Shared types and the fixed register map for the 4-tap FIR controller.
package fir_pkg;

  localparam int unsigned OP_W    = 3;
  localparam int unsigned STATE_W = 5;

  typedef enum logic [OP_W-1:0] {
    OP_NOP  = 3'd0,
    OP_COPY = 3'd1,
    OP_LOAD = 3'd2,
    OP_ADD  = 3'd4,
    OP_SUB  = 3'd5,
    OP_MUL  = 3'd6
  } op_t;

  typedef enum logic [STATE_W-1:0] {
    IDLE, SORT1, SORT2, SORT3, STORE, ZERO,
    MUL1, ADD1, MUL2, SUB2, MUL3, ADD3, MUL4, SUB4,
    EIDLE,
    LDF0, WT0, LDF1, WT1, LDF2, WT2, LDF3, WT3
  } ctrl_state_t;

  // Datapath register-file map
  localparam int unsigned R_ACC = 0;
  localparam int unsigned R_S1  = 1;
  localparam int unsigned R_S2  = 2;
  localparam int unsigned R_S3  = 3;
  localparam int unsigned R_S4  = 4;
  localparam int unsigned R_F0  = 5;
  localparam int unsigned R_F1  = 6;
  localparam int unsigned R_F2  = 7;
  localparam int unsigned R_F3  = 8;
  localparam int unsigned R_TMP = 9;

endpackage

// File: rtl/fir_controller_if.sv
// Control bundle between the FIR sequencer, the AHB-lite slave and the datapath.
interface fir_controller_if #(parameter int unsigned RADDR_W = 4);
  import fir_pkg::*;

  logic               dr;
  logic               lc;
  logic               overflow;
  op_t                op;
  logic [RADDR_W-1:0] src1;
  logic [RADDR_W-1:0] src2;
  logic [RADDR_W-1:0] dest;
  logic               ext_sel;
  logic [1:0]         coefficient_num;
  logic               cnt_up;
  logic               modwait;
  logic               err;

  modport master (
    input  dr, lc, overflow,
    output op, src1, src2, dest, ext_sel, coefficient_num, cnt_up, modwait, err
  );

  modport slave (
    output dr, lc, overflow,
    input  op, src1, src2, dest, ext_sel, coefficient_num, cnt_up, modwait, err
  );
endinterface

// File: rtl/fir_controller.sv
// Moore sequencer for the 4-tap FIR datapath: sample shift/load, MAC sequence, coefficient load.
module fir_controller
  import fir_pkg::*;
#(
  parameter int unsigned RADDR_W = 4
) (
  input  logic               clk,
  input  logic               n_rst,
  fir_controller_if.master   bus
);

  ctrl_state_t        state, state_n;
  op_t                op_n;
  logic [RADDR_W-1:0] src1_n, src2_n, dest_n;
  logic               ext_sel_n, cnt_up_n, modwait_n, err_n;
  logic [1:0]         coef_n;

  // State register; outputs are registered as the decode of the incoming state
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state               <= IDLE;
      bus.op              <= OP_NOP;
      bus.src1            <= '0;
      bus.src2            <= '0;
      bus.dest            <= '0;
      bus.ext_sel         <= 1'b0;
      bus.coefficient_num <= 2'd0;
      bus.cnt_up          <= 1'b0;
      bus.modwait         <= 1'b0;
      bus.err             <= 1'b0;
    end else begin
      state               <= state_n;
      bus.op              <= op_n;
      bus.src1            <= src1_n;
      bus.src2            <= src2_n;
      bus.dest            <= dest_n;
      bus.ext_sel         <= ext_sel_n;
      bus.coefficient_num <= coef_n;
      bus.cnt_up          <= cnt_up_n;
      bus.modwait         <= modwait_n;
      bus.err             <= err_n;
    end
  end

  // Next-state selection and output decode of that next state
  always_comb begin
    state_n   = state;
    op_n      = OP_NOP;
    src1_n    = '0;
    src2_n    = '0;
    dest_n    = '0;
    ext_sel_n = 1'b0;
    coef_n    = 2'd0;
    cnt_up_n  = 1'b0;
    err_n     = 1'b0;

    case (state)
      IDLE, EIDLE: begin
        if (bus.dr)      state_n = SORT1;
        else if (bus.lc) state_n = LDF0;
      end
      SORT1: state_n = SORT2;
      SORT2: state_n = SORT3;
      SORT3: state_n = STORE;
      STORE: state_n = ZERO;
      ZERO:  state_n = MUL1;
      MUL1:  state_n = ADD1;
      ADD1:  state_n = bus.overflow ? EIDLE : MUL2;
      MUL2:  state_n = SUB2;
      SUB2:  state_n = bus.overflow ? EIDLE : MUL3;
      MUL3:  state_n = ADD3;
      ADD3:  state_n = bus.overflow ? EIDLE : MUL4;
      MUL4:  state_n = SUB4;
      SUB4:  state_n = bus.overflow ? EIDLE : IDLE;
      LDF0:  state_n = WT0;
      WT0:   state_n = LDF1;
      LDF1:  state_n = WT1;
      WT1:   state_n = LDF2;
      LDF2:  state_n = WT2;
      WT2:   state_n = LDF3;
      LDF3:  state_n = WT3;
      WT3:   state_n = IDLE;
      default: state_n = IDLE;
    endcase

    modwait_n = !(state_n inside {IDLE, EIDLE});

    case (state_n)
      SORT1: begin op_n = OP_COPY; src1_n = RADDR_W'(R_S3); dest_n = RADDR_W'(R_S4); end
      SORT2: begin op_n = OP_COPY; src1_n = RADDR_W'(R_S2); dest_n = RADDR_W'(R_S3); end
      SORT3: begin op_n = OP_COPY; src1_n = RADDR_W'(R_S1); dest_n = RADDR_W'(R_S2); end
      STORE: begin op_n = OP_LOAD; dest_n = RADDR_W'(R_S1); cnt_up_n = 1'b1; end
      ZERO: begin
        op_n = OP_SUB; src1_n = RADDR_W'(R_ACC); src2_n = RADDR_W'(R_ACC); dest_n = RADDR_W'(R_ACC);
      end
      MUL1: begin op_n = OP_MUL; src1_n = RADDR_W'(R_S1); src2_n = RADDR_W'(R_F0); dest_n = RADDR_W'(R_TMP); end
      MUL2: begin op_n = OP_MUL; src1_n = RADDR_W'(R_S2); src2_n = RADDR_W'(R_F1); dest_n = RADDR_W'(R_TMP); end
      MUL3: begin op_n = OP_MUL; src1_n = RADDR_W'(R_S3); src2_n = RADDR_W'(R_F2); dest_n = RADDR_W'(R_TMP); end
      MUL4: begin op_n = OP_MUL; src1_n = RADDR_W'(R_S4); src2_n = RADDR_W'(R_F3); dest_n = RADDR_W'(R_TMP); end
      ADD1, ADD3: begin
        op_n = OP_ADD; src1_n = RADDR_W'(R_ACC); src2_n = RADDR_W'(R_TMP); dest_n = RADDR_W'(R_ACC);
      end
      SUB2, SUB4: begin
        op_n = OP_SUB; src1_n = RADDR_W'(R_ACC); src2_n = RADDR_W'(R_TMP); dest_n = RADDR_W'(R_ACC);
      end
      EIDLE: err_n = 1'b1;
      LDF0: begin op_n = OP_LOAD; dest_n = RADDR_W'(R_F0); ext_sel_n = 1'b1; coef_n = 2'd0; end
      WT0:  coef_n = 2'd0;
      LDF1: begin op_n = OP_LOAD; dest_n = RADDR_W'(R_F1); ext_sel_n = 1'b1; coef_n = 2'd1; end
      WT1:  coef_n = 2'd1;
      LDF2: begin op_n = OP_LOAD; dest_n = RADDR_W'(R_F2); ext_sel_n = 1'b1; coef_n = 2'd2; end
      WT2:  coef_n = 2'd2;
      LDF3: begin op_n = OP_LOAD; dest_n = RADDR_W'(R_F3); ext_sel_n = 1'b1; coef_n = 2'd3; end
      WT3:  coef_n = 2'd3;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fir_controller.sv
// Directed bench for fir_controller: sample path, coefficient path, overflow and reset.
module tb_fir_controller;
  import fir_pkg::*;

  localparam int unsigned RADDR_W = 4;

  logic clk;
  logic n_rst;
  int   vec_cnt;
  int   miss_cnt;

  fir_controller_if #(.RADDR_W(RADDR_W)) bus ();

  fir_controller #(.RADDR_W(RADDR_W)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-derived decode for SORT1..SUB4
  int exp_op   [13] = '{1, 1, 1, 2, 5, 6, 4, 6, 5, 6, 4, 6, 5};
  int exp_src1 [13] = '{3, 2, 1, 0, 0, 1, 0, 2, 0, 3, 0, 4, 0};
  int exp_src2 [13] = '{0, 0, 0, 0, 0, 5, 9, 6, 9, 7, 9, 8, 9};
  int exp_dest [13] = '{4, 3, 2, 1, 0, 9, 0, 9, 0, 9, 0, 9, 0};

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_idle(input string tag, input logic exp_err);
    check_vec({tag, "_op"},      32'(bus.op), 32'd0);
    check_vec({tag, "_dest"},    32'(bus.dest), 32'd0);
    check_vec({tag, "_modwait"}, 32'(bus.modwait), 32'd0);
    check_vec({tag, "_err"},     32'(bus.err), 32'(exp_err));
    check_vec({tag, "_cnt_up"},  32'(bus.cnt_up), 32'd0);
    check_vec({tag, "_coef"},    32'(bus.coefficient_num), 32'd0);
  endtask

  // Call with dr already raised in an idle cycle; stops after cycle stop_idx
  task automatic run_sample(input string tag, input int ov_idx, input int stop_idx);
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      bus.dr = 1'b0;
      check_vec($sformatf("%s_s%0d_op", tag, i),   32'(bus.op),   32'(exp_op[i]));
      check_vec($sformatf("%s_s%0d_src1", tag, i), 32'(bus.src1), 32'(exp_src1[i]));
      check_vec($sformatf("%s_s%0d_src2", tag, i), 32'(bus.src2), 32'(exp_src2[i]));
      check_vec($sformatf("%s_s%0d_dest", tag, i), 32'(bus.dest), 32'(exp_dest[i]));
      check_vec($sformatf("%s_s%0d_cnt", tag, i),  32'(bus.cnt_up), (i == 3) ? 32'd1 : 32'd0);
      check_vec($sformatf("%s_s%0d_ext", tag, i),  32'(bus.ext_sel), 32'd0);
      check_vec($sformatf("%s_s%0d_mw", tag, i),   32'(bus.modwait), 32'd1);
      check_vec($sformatf("%s_s%0d_err", tag, i),  32'(bus.err), 32'd0);
      bus.overflow = (i == ov_idx);
      if (i == stop_idx) break;
    end
  endtask

  // Call with lc already raised; the slave drops lc once it sees coefficient 3
  task automatic run_coef(input string tag);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_vec($sformatf("%s_c%0d_op", tag, i),   32'(bus.op), (i % 2 == 0) ? 32'd2 : 32'd0);
      check_vec($sformatf("%s_c%0d_dest", tag, i), 32'(bus.dest), (i % 2 == 0) ? 32'(5 + i / 2) : 32'd0);
      check_vec($sformatf("%s_c%0d_ext", tag, i),  32'(bus.ext_sel), (i % 2 == 0) ? 32'd1 : 32'd0);
      check_vec($sformatf("%s_c%0d_coef", tag, i), 32'(bus.coefficient_num), 32'(i / 2));
      check_vec($sformatf("%s_c%0d_mw", tag, i),   32'(bus.modwait), 32'd1);
      if (i == 6) bus.lc = 1'b0;
    end
  endtask

  initial begin
    vec_cnt      = 0;
    miss_cnt     = 0;
    n_rst        = 1'b0;
    bus.dr       = 1'b0;
    bus.lc       = 1'b0;
    bus.overflow = 1'b0;

    repeat (2) @(negedge clk);
    check_idle("reset", 1'b0);
    n_rst = 1'b1;
    @(negedge clk);
    check_idle("idle0", 1'b0);

    // Plain sample
    bus.dr = 1'b1;
    run_sample("samp", -1, 12);
    @(negedge clk);
    check_idle("samp_end", 1'b0);

    // Coefficient load
    bus.lc = 1'b1;
    run_coef("coef");
    @(negedge clk);
    check_idle("coef_end", 1'b0);

    // dr and lc together: sample first, then coefficients straight after
    bus.dr = 1'b1;
    bus.lc = 1'b1;
    run_sample("both", -1, 12);
    @(negedge clk);
    check_idle("both_mid", 1'b0);
    run_coef("both");
    @(negedge clk);
    check_idle("both_end", 1'b0);

    // Overflow during SUB2 traps in EIDLE until dr
    bus.dr = 1'b1;
    run_sample("ovf", 8, 8);
    @(negedge clk);
    bus.overflow = 1'b0;
    check_idle("ovf_e0", 1'b1);
    repeat (3) begin
      @(negedge clk);
      check_idle("ovf_hold", 1'b1);
    end
    bus.dr = 1'b1;
    run_sample("ovf_rec", -1, 12);
    @(negedge clk);
    check_idle("ovf_rec_end", 1'b0);

    // Overflow in non-arithmetic-check states is ignored
    bus.dr = 1'b1;
    run_sample("ovz", 4, 12);
    @(negedge clk);
    bus.overflow = 1'b0;
    check_idle("ovz_end", 1'b0);
    bus.dr = 1'b1;
    run_sample("ovm", 9, 12);
    @(negedge clk);
    bus.overflow = 1'b0;
    check_idle("ovm_end", 1'b0);

    // Reset in MUL2 and restart
    bus.dr = 1'b1;
    run_sample("rst", -1, 7);
    n_rst = 1'b0;
    #1;
    check_idle("rst_async", 1'b0);
    @(negedge clk);
    check_idle("rst_hold", 1'b0);
    n_rst = 1'b1;
    @(negedge clk);
    check_idle("rst_rel", 1'b0);
    bus.dr = 1'b1;
    run_sample("rst_rs", -1, 12);
    @(negedge clk);
    check_idle("rst_rs_end", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
